// File: rtl/mcdf_pkg.sv
// MCDF shared definitions: channel constants, FSM states and
// the packet-length code decoder used by the arbiter/formatter.
package mcdf_pkg;

  localparam int CH_NUM = 3;
  localparam int CHID_W = 2;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_SEND
  } fsm_e;

  function automatic logic [LEN_W-1:0] pkglen_decode(
    input logic [2:0] code
  );
    logic [LEN_W-1:0] len;
    unique case (code)
      3'd0:    len = 6'd4;
      3'd1:    len = 6'd8;
      3'd2:    len = 6'd16;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

  function automatic logic [CHID_W-1:0] next_ch(
    input logic [CHID_W-1:0] c
  );
    return (c >= 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

endpackage

// File: rtl/mcdf_arbiter_formatter_if.sv
// Formatter output bus toward the downstream consumer.
// master = formatter, slave = consumer.
interface mcdf_arbiter_formatter_if #(
  parameter int DW = 32
);
  import mcdf_pkg::*;

  logic              fmt_req;
  logic              fmt_grant;
  logic [CHID_W-1:0] fmt_chid;
  logic [LEN_W-1:0]  fmt_length;
  logic              fmt_val;
  logic              fmt_start;
  logic              fmt_end;
  logic [DW-1:0]     fmt_data;

  modport master (
    output fmt_req,
    output fmt_chid,
    output fmt_length,
    output fmt_val,
    output fmt_start,
    output fmt_end,
    output fmt_data,
    input  fmt_grant
  );

  modport slave (
    input  fmt_req,
    input  fmt_chid,
    input  fmt_length,
    input  fmt_val,
    input  fmt_start,
    input  fmt_end,
    input  fmt_data,
    output fmt_grant
  );

endinterface

// File: rtl/mcdf_rr_arbiter.sv
// Three-way round-robin arbiter; the search starts at the
// pointer and wraps, so the pointer channel has top priority.
module mcdf_rr_arbiter
  import mcdf_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  logic [CHID_W-1:0] ptr,
  input  logic              en,
  output logic [CH_NUM-1:0] grant,
  output logic [CHID_W-1:0] id
);

  logic [CHID_W-1:0] o0;
  logic [CHID_W-1:0] o1;
  logic [CHID_W-1:0] o2;

  // Search order derived from the pointer; an out-of-range
  // pointer is treated as channel 0.
  always_comb begin
    o0 = (ptr > 2'd2) ? 2'd0 : ptr;
    o1 = next_ch(o0);
    o2 = next_ch(o1);
  end

  // First requester in search order wins.
  always_comb begin
    grant = '0;
    id    = '0;
    if (en) begin
      if (req[o0]) begin
        id = o0;
        grant[o0] = 1'b1;
      end else if (req[o1]) begin
        id = o1;
        grant[o1] = 1'b1;
      end else if (req[o2]) begin
        id = o2;
        grant[o2] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter_formatter.sv
// MCDF arbiter/formatter: picks a slave FIFO, acknowledges it
// and re-emits its packet as a framed stream.
module mcdf_arbiter_formatter
  import mcdf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CH_NUM-1:0] slv_req_i,
  input  logic [CH_NUM-1:0] slv_val_i,
  input  logic [DW-1:0]     slv0_data_i,
  input  logic [DW-1:0]     slv1_data_i,
  input  logic [DW-1:0]     slv2_data_i,
  input  logic [2:0]        slv0_pkglen_i,
  input  logic [2:0]        slv1_pkglen_i,
  input  logic [2:0]        slv2_pkglen_i,
  output logic [CH_NUM-1:0] a2s_ack_o,
  mcdf_arbiter_formatter_if.master fmt
);

  fsm_e              st;
  fsm_e              st_nxt;
  logic [CHID_W-1:0] ptr_q;
  logic [CHID_W-1:0] win_id;
  logic [CH_NUM-1:0] win_oh;
  logic [CHID_W-1:0] chid_q;
  logic [CH_NUM-1:0] ack_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_sel;
  logic [LEN_W-1:0]  cnt_q;
  logic              any_req;
  logic              pick;
  logic              take;
  logic              last;
  logic              val_sel;
  logic [DW-1:0]     data_sel;
  logic              val_q;
  logic              sop_q;
  logic              eop_q;
  logic [DW-1:0]     data_q;

  assign any_req = |slv_req_i;
  assign pick    = (st == ST_IDLE) && any_req;

  mcdf_rr_arbiter u_arb (
    .req   (slv_req_i),
    .ptr   (ptr_q),
    .en    (st == ST_IDLE),
    .grant (win_oh),
    .id    (win_id)
  );

  // Decoded length of the channel about to win.
  always_comb begin
    len_sel = '0;
    unique case (win_id)
      2'd0:    len_sel = pkglen_decode(slv0_pkglen_i);
      2'd1:    len_sel = pkglen_decode(slv1_pkglen_i);
      2'd2:    len_sel = pkglen_decode(slv2_pkglen_i);
      default: len_sel = '0;
    endcase
  end

  // Only the owning channel's valid/data reach the datapath.
  always_comb begin
    val_sel  = 1'b0;
    data_sel = '0;
    unique case (chid_q)
      2'd0: begin
        val_sel  = slv_val_i[0];
        data_sel = slv0_data_i;
      end
      2'd1: begin
        val_sel  = slv_val_i[1];
        data_sel = slv1_data_i;
      end
      2'd2: begin
        val_sel  = slv_val_i[2];
        data_sel = slv2_data_i;
      end
      default: begin
        val_sel  = 1'b0;
        data_sel = '0;
      end
    endcase
  end

  // Words are taken until the last one has been emitted; the
  // cycle showing end-of-packet ignores further input.
  assign take = (st == ST_SEND) && !eop_q && val_sel;
  assign last = (cnt_q == len_q - 6'd1);

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE: if (any_req)       st_nxt = ST_REQ;
      ST_REQ:  if (fmt.fmt_grant) st_nxt = ST_ACK;
      ST_ACK:                     st_nxt = ST_SEND;
      ST_SEND: if (eop_q)         st_nxt = ST_IDLE;
      default:                    st_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) st <= ST_IDLE;
    else         st <= st_nxt;
  end

  // Winner id, length and ack mask frozen for the packet.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      chid_q <= '0;
      len_q  <= '0;
      ack_q  <= '0;
    end else if (pick) begin
      chid_q <= win_id;
      len_q  <= len_sel;
      ack_q  <= win_oh;
    end
  end

  // Priority pointer moves past the channel just served.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      ptr_q <= '0;
    else if ((st == ST_SEND) && eop_q)
      ptr_q <= next_ch(chid_q);
  end

  // Word counter, cleared between packets.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      cnt_q <= '0;
    else if (st == ST_IDLE)
      cnt_q <= '0;
    else if (take)
      cnt_q <= last ? '0 : cnt_q + 6'd1;
  end

  // Registered output stream with framing flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      val_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q <= take;
      sop_q <= take && (cnt_q == '0);
      eop_q <= take && last;
      if (take) data_q <= data_sel;
    end
  end

  assign a2s_ack_o      = (st == ST_ACK) ? ack_q : '0;
  assign fmt.fmt_req    = (st == ST_REQ);
  assign fmt.fmt_chid   = chid_q;
  assign fmt.fmt_length = len_q;
  assign fmt.fmt_val    = val_q;
  assign fmt.fmt_start  = sop_q;
  assign fmt.fmt_end    = eop_q;
  assign fmt.fmt_data   = data_q;

endmodule

// File: doc/mcdf_arbiter_formatter.md
# mcdf_arbiter_formatter

Downstream end of the MCDF slave-FIFO data path. Arbitrates round-robin among three slave FIFOs raising `slvx_req`, grants one with a single-cycle `a2sx_ack` pulse, collects that slave's packet words on `slvx_val`/`slvx_data`, and re-emits them as a framed packet on the formatter output interface. It issues the acknowledge that each slave FIFO waits for, and it consumes the stream the slave produces after that acknowledge.

## Interface
- `DW`, 32, data word width; must match slave FIFO `slvx_data` width.
- `clk_i`  in  1  system clock, rising edge.
- `rstn_i`  in  1  asynchronous active-low reset.
- `slv_req_i`  in  3  bit x = slave x holds at least one full packet.
- `slv_val_i`  in  3  bit x = `slvx_data_i` valid this cycle.
- `slv0_data_i`, `slv1_data_i`, `slv2_data_i`  in  DW  slave data words.
- `slv0_pkglen_i`, `slv1_pkglen_i`, `slv2_pkglen_i`  in  3  packet-length code: 0→4, 1→8, 2→16, 3..7→32 words.
- `a2s_ack_o`  out  3  one-hot, single-cycle acknowledge to the winning slave.
- `fmt_req_o`  out  1  packet pending toward the downstream consumer.
- `fmt_grant_i`  in  1  downstream accepts the pending packet.
- `fmt_chid_o`  out  2  channel id of the current packet (0..2).
- `fmt_length_o`  out  6  decoded word count (4/8/16/32).
- `fmt_val_o`  out  1  `fmt_data_o` valid.
- `fmt_start_o`  out  1  first word of the packet.
- `fmt_end_o`  out  1  last word of the packet.
- `fmt_data_o`  out  DW  packet data.

## Operation
- FSM states: IDLE, REQ, ACK, SEND.
- IDLE: if any `slv_req_i` bit is set, the round-robin arbiter picks the winner and the FSM moves to REQ. Latch the winner id and the decoded length of its `pkglen` at that point; they stay frozen until the FSM returns to IDLE.
- REQ: hold `fmt_req_o`=1 until `fmt_grant_i` is sampled high, then move to ACK. No timeout; the FSM waits indefinitely.
- ACK: drive `a2s_ack_o[id]`=1 for exactly this cycle, then move to SEND.
- SEND:
  - Each cycle `slv_val_i[id]`=1, register the winner's data to `fmt_data_o` with `fmt_val_o`=1 and increment the word counter.
  - `fmt_start_o` accompanies word 0; `fmt_end_o` accompanies word length-1.
  - After the last word, return to IDLE and move the priority pointer to id+1 mod 3.
- Gaps: a `slv_val_i[id]`=0 cycle inserts a bubble (`fmt_val_o`=0) without advancing the counter.
- `slv_val_i` bits of non-winners are ignored in every state.
- Round-robin:
  - Search order starts at the pointer.
  - Pointer resets to 0.
  - With all three requesting continuously, grant order is 0,1,2,0,...
- Word counter is 6 bits and compares against length-1; it never wraps past 31.

## Timing
- Reset values: `a2s_ack_o`=0, `fmt_req_o`=0, `fmt_val_o`=0, `fmt_start_o`=0, `fmt_end_o`=0, `fmt_data_o`=0, `fmt_chid_o`=0, `fmt_length_o`=0. FSM goes to IDLE and the pointer goes to 0.
- Reset asserted mid-packet aborts immediately. No partial `fmt_end_o` is emitted. After release the FSM restarts from IDLE.
- `slv_req_i` seen in cycle T (IDLE) → `fmt_req_o`=1 from T+1.
- `fmt_grant_i` high at the T edge (REQ) → `fmt_req_o`=0 and `a2s_ack_o` pulse at T+1.
- Data latency: `slv_val_i` at cycle T → `fmt_val_o`/`fmt_data_o` at T+1.
- `fmt_chid_o` and `fmt_length_o` are valid from the first `fmt_req_o` cycle through the `fmt_end_o` cycle.
- Minimum gap between packets: `fmt_end_o` at T → earliest next `fmt_req_o` at T+2 (one IDLE cycle).
- `fmt_grant_i` outside REQ is ignored.
- Winner's `slv_req_i` dropping after selection does not cancel the packet.

## Structure
- Shared package `mcdf_pkg`:
  - `pkglen_decode` function (3-bit code → 6-bit length).
  - FSM state enum.
  - Channel-count constant (3).
  - Channel-id width constant (2).
- Sub-module `mcdf_rr_arbiter`: 3-way round-robin. Inputs are request vector, pointer and enable; outputs are a one-hot grant and an encoded id. The FSM and datapath stay in the top module.

## Test plan
- Slave 0 only, pkglen=0, data 0x10..0x13 back-to-back, grant one cycle after request:
  - exactly one `a2s_ack_o`=3'b001 pulse.
  - four `fmt_val_o` words 0x10..0x13.
  - `fmt_start_o` on 0x10, `fmt_end_o` on 0x13, `fmt_chid_o`=0, `fmt_length_o`=4.
- All three slaves requesting continuously, pkglen=1 each → packets emitted in channel order 0,1,2,0, each 8 words with a correct `fmt_end_o`.
- Slave 2, pkglen=3, `slv_val_i` toggled 1,0,1,0 → exactly 32 output words with no duplicates, bubbles preserved, `fmt_end_o` on word 31.
- `fmt_grant_i` held low 50 cycles → `fmt_req_o` stays high, no `a2s_ack_o` pulse; grant at cycle 51 → ack on the next cycle.
- `slv_val_i[1]` pulsed while slave 0 owns the bus → ignored; output matches slave 0's data only.
- `rstn_i` low at word 5 of a 16-word packet → all outputs 0 asynchronously; after release, a new request restarts at `fmt_start_o` with pointer 0.
